// File: rtl/ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_stage_pkg
//   Shared definitions for the St.PU execute stage: ALU operation codes,
//   result-type select codes, divider FSM encoding, and the helpers used
//   by the iterative divider (one restoring step, conditional negate).
// ---------------------------------------------------------------------------
package ex_stage_pkg;

   // Number of restoring-division iterations (equals the operand width)
   localparam int DIV_CYCLES = 32;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   // aluop codes
   localparam logic [7:0] EXE_OR_OP   = 8'h25;
   localparam logic [7:0] EXE_AND_OP  = 8'h24;
   localparam logic [7:0] EXE_XOR_OP  = 8'h26;
   localparam logic [7:0] EXE_NOR_OP  = 8'h27;
   localparam logic [7:0] EXE_SLL_OP  = 8'h7C;
   localparam logic [7:0] EXE_SRL_OP  = 8'h02;
   localparam logic [7:0] EXE_SRA_OP  = 8'h03;
   localparam logic [7:0] EXE_DIV_OP  = 8'h1A;
   localparam logic [7:0] EXE_DIVU_OP = 8'h1B;

   // alusel codes
   localparam logic [2:0] EXE_RES_NOP   = 3'b000;
   localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      DIV_ON      = 2'b01,
      DIV_BY_ZERO = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;

   // One restoring shift-subtract step on the 65-bit partial remainder.
   // Layout: [64:32] running remainder, [31:0] dividend bits / quotient bits.
   function automatic logic [64:0] div_step(input logic [64:0] rem,
                                            input logic [31:0] dvs);
      logic [64:0] sh;
      logic [32:0] diff;
      sh   = rem << 1;
      diff = sh[64:32] - {1'b0, dvs};
      // A borrow (bit 32 set) means the divisor did not fit: keep the shift
      if (diff[32] == 1'b0) begin
         div_step = {diff, sh[31:1], 1'b1};
      end else begin
         div_step = sh;
      end
   endfunction

   // Two's-complement negate when neg is set
   function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
      if (neg) begin
         neg_if = 32'd0 - v;
      end else begin
         neg_if = v;
      end
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ---------------------------------------------------------------------------
// ex_stage_if
//   Bundle between decode (master) and the execute stage (slave).
//   master drives: flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i
//   slave drives : wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
// ---------------------------------------------------------------------------
interface ex_stage_if;
   logic        flush_i;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i;
   logic [31:0] reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        whilo_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        stallreq_o;

   modport master (
      output flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
      input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
   );

   modport slave (
      input  flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
      output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
   );
endinterface

// File: rtl/ex_stage_div_unit.sv
// ---------------------------------------------------------------------------
// ex_stage_div_unit
//   Iterative radix-2 restoring divider for DIV/DIVU.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     flush_i       abandon any divide in progress
//     start_i       a DIV/DIVU is present at the input
//     signed_i      1 for DIV, 0 for DIVU
//     dividend_i    operand 1, divisor_i operand 2
//     stallreq_o    stall request while the divide is outstanding
//     whilo_o       one-cycle result strobe; hi_o remainder, lo_o quotient
//   The accept cycle already performs the first iteration on the latched
//   magnitudes, so DIV_ON runs the remaining 31 steps (cnt 0..30) and the
//   result appears 33 cycles after acceptance. A zero divisor is resolved in
//   the accept cycle itself, giving a 2-cycle latency.
// ---------------------------------------------------------------------------
module ex_stage_div_unit
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic        start_i,
   input  logic        signed_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic        stallreq_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   div_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [64:0] rem_q, rem_d;
   logic [31:0] dvs_q, dvs_d;
   logic        neg_quot_q, neg_quot_d;
   logic        neg_rem_q, neg_rem_d;
   logic        whilo_q, whilo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [31:0] dvd_abs_s;
   logic [31:0] dvs_abs_s;
   logic [64:0] step_s;

   // Operand magnitudes (raw values for DIVU) and the next iteration result
   always_comb begin
      dvd_abs_s = neg_if(signed_i & dividend_i[31], dividend_i);
      dvs_abs_s = neg_if(signed_i & divisor_i[31], divisor_i);
      step_s    = div_step(rem_q, dvs_q);
   end

   // Next-state and datapath computation for the divider FSM
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      dvs_d      = dvs_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      whilo_d    = 1'b0;
      hi_d       = ZeroWord;
      lo_d       = ZeroWord;
      if (flush_i) begin
         state_d = IDLE;
         cnt_d   = 5'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i && (divisor_i == ZeroWord)) begin
                  // quotient = remainder = 0, presented next cycle
                  state_d = DIV_END;
                  whilo_d = 1'b1;
               end else if (start_i) begin
                  state_d    = DIV_ON;
                  cnt_d      = 5'd0;
                  dvs_d      = dvs_abs_s;
                  rem_d      = div_step({33'd0, dvd_abs_s}, dvs_abs_s);
                  neg_quot_d = signed_i & (dividend_i[31] ^ divisor_i[31]);
                  neg_rem_d  = signed_i & dividend_i[31];
               end else begin
                  state_d = IDLE;
               end
            end
            DIV_ON: begin
               rem_d = step_s;
               cnt_d = cnt_q + 5'd1;
               if (cnt_d == 5'(DIV_CYCLES - 1)) begin
                  state_d = DIV_END;
                  whilo_d = 1'b1;
                  lo_d    = neg_if(neg_quot_q, step_s[31:0]);
                  hi_d    = neg_if(neg_rem_q, step_s[63:32]);
               end else begin
                  state_d = DIV_ON;
               end
            end
            DIV_BY_ZERO: begin
               state_d = DIV_END;
               whilo_d = 1'b1;
            end
            DIV_END: begin
               state_d = IDLE;
               cnt_d   = 5'd0;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 5'd0;
            end
         endcase
      end
   end

   // Divider state and registered result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 5'd0;
         rem_q      <= 65'd0;
         dvs_q      <= 32'd0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         whilo_q    <= 1'b0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         dvs_q      <= dvs_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         whilo_q    <= whilo_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   // Stall request: depends on the live input in IDLE, and drops at once on flush
   always_comb begin
      if (rst || flush_i) begin
         stallreq_o = 1'b0;
      end else begin
         case (state_q)
            IDLE:        stallreq_o = start_i;
            DIV_ON:      stallreq_o = 1'b1;
            DIV_BY_ZERO: stallreq_o = 1'b1;
            default:     stallreq_o = 1'b0;
         endcase
      end
   end

   // A flush arriving in the DIV_END cycle suppresses the HI/LO write
   always_comb begin
      whilo_o = whilo_q & ~flush_i;
      hi_o    = hi_q;
      lo_o    = lo_q;
   end

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
//   Execute stage of St.PU. Logic and shift results are combinational in
//   the cycle the operands arrive; DIV/DIVU go to the iterative divider,
//   which stalls the pipeline until HI/LO are ready.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     ex         ex_stage_if.slave: decode operands in; wd/wreg/wdata,
//                HI/LO write and stall request out. wd_o/wreg_o/wdata_o
//                also feed decode forwarding.
//   All outputs read 0 while rst is high.
// ---------------------------------------------------------------------------
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   ex_stage_if.slave  ex
);

   logic [31:0] logic_res_s;
   logic [31:0] shift_res_s;
   logic [4:0]  shamt_s;
   logic        div_start_s;
   logic        div_signed_s;
   logic        stallreq_s;
   logic        whilo_s;
   logic [31:0] hi_s;
   logic [31:0] lo_s;

   // Logic unit
   always_comb begin
      case (ex.aluop_i)
         EXE_OR_OP:  logic_res_s = ex.reg1_i | ex.reg2_i;
         EXE_AND_OP: logic_res_s = ex.reg1_i & ex.reg2_i;
         EXE_XOR_OP: logic_res_s = ex.reg1_i ^ ex.reg2_i;
         EXE_NOR_OP: logic_res_s = ~(ex.reg1_i | ex.reg2_i);
         default:    logic_res_s = ZeroWord;
      endcase
   end

   // Shifter: only the low five bits of reg1 form the amount
   always_comb begin
      shamt_s = ex.reg1_i[4:0];
      case (ex.aluop_i)
         EXE_SLL_OP: shift_res_s = ex.reg2_i << shamt_s;
         EXE_SRL_OP: shift_res_s = ex.reg2_i >> shamt_s;
         EXE_SRA_OP: shift_res_s = $signed(ex.reg2_i) >>> shamt_s;
         default:    shift_res_s = ZeroWord;
      endcase
   end

   // Divide request decode
   always_comb begin
      div_start_s  = (ex.aluop_i == EXE_DIV_OP) || (ex.aluop_i == EXE_DIVU_OP);
      div_signed_s = (ex.aluop_i == EXE_DIV_OP);
   end

   ex_stage_div_unit u_div (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (ex.flush_i),
      .start_i    (div_start_s),
      .signed_i   (div_signed_s),
      .dividend_i (ex.reg1_i),
      .divisor_i  (ex.reg2_i),
      .stallreq_o (stallreq_s),
      .whilo_o    (whilo_s),
      .hi_o       (hi_s),
      .lo_o       (lo_s)
   );

   // Result select and write-back fields, forced to 0 during reset
   always_comb begin
      if (rst) begin
         ex.wdata_o = ZeroWord;
         ex.wd_o    = 5'd0;
         ex.wreg_o  = 1'b0;
      end else begin
         case (ex.alusel_i)
            EXE_RES_NOP:   ex.wdata_o = ZeroWord;
            EXE_RES_LOGIC: ex.wdata_o = logic_res_s;
            EXE_RES_SHIFT: ex.wdata_o = shift_res_s;
            default:       ex.wdata_o = ZeroWord;
         endcase
         ex.wd_o   = ex.wd_i;
         ex.wreg_o = ex.wreg_i;
      end
   end

   // Divider outputs onto the interface
   always_comb begin
      ex.stallreq_o = stallreq_s;
      ex.whilo_o    = whilo_s;
      ex.hi_o       = hi_s;
      ex.lo_o       = lo_s;
   end

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage
//   Directed bench for ex_stage. Divide results are pushed to a scoreboard
//   queue when issued and popped by a monitor whenever whilo_o is seen.
//   ALU, stall and reset behaviour is compared directly by the stimulus.
// ---------------------------------------------------------------------------
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ex_stage_if ex_if ();

   ex_stage dut (
      .clk (clk),
      .rst (rst),
      .ex  (ex_if)
   );

   int          checks = 0;
   int          fails  = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_exp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [4:0] wd, input logic wreg);
      ex_if.aluop_i  = op;
      ex_if.alusel_i = sel;
      ex_if.reg1_i   = r1;
      ex_if.reg2_i   = r2;
      ex_if.wd_i     = wd;
      ex_if.wreg_i   = wreg;
   endtask

   task automatic alu_check(input string name, input logic [7:0] op, input logic [2:0] sel,
                            input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] exp);
      @(posedge clk); #1;
      drive(op, sel, r1, r2, 5'd3, 1'b1);
      @(negedge clk);
      chk(name, ex_if.wdata_o, exp);
   endtask

   task automatic run_div(input string name, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_stall);
      int n;
      exp_q.push_back({exp_hi, exp_lo});
      @(posedge clk); #1;
      drive(op, EXE_RES_NOP, a, b, 5'd0, 1'b0);
      n = 0;
      @(negedge clk);
      while (ex_if.stallreq_o === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
      chk({name, "_whilo"}, {31'd0, ex_if.whilo_o}, 32'd1);
   endtask

   task automatic go_idle(input string name);
      @(posedge clk); #1;
      drive(8'h00, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      chk({name, "_idle_stall"}, {31'd0, ex_if.stallreq_o}, 32'd0);
      chk({name, "_idle_whilo"}, {31'd0, ex_if.whilo_o}, 32'd0);
   endtask

   task automatic watch_no_whilo(input string name, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (ex_if.whilo_o === 1'b1) pulses++;
      end
      chk({name, "_whilo_pulses"}, 32'(pulses), 32'd0);
   endtask

   // Scoreboard monitor: every HI/LO write must match the oldest pending divide
   always @(negedge clk) begin
      if (rst === 1'b0 && ex_if.whilo_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_whilo: actual whilo_o=1 hi=0x%08h lo=0x%08h, required whilo_o=0",
                     ex_if.hi_o, ex_if.lo_o);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("div_hi", ex_if.hi_o, mon_exp[63:32]);
            chk("div_lo", ex_if.lo_o, mon_exp[31:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      ex_if.flush_i = 1'b0;
      drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F0F0, 5'd5, 1'b1);
      @(negedge clk);
      chk("rst_wdata", ex_if.wdata_o, 32'd0);
      chk("rst_wd", {27'd0, ex_if.wd_o}, 32'd0);
      chk("rst_wreg", {31'd0, ex_if.wreg_o}, 32'd0);
      drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd5, 1'b1);
      @(negedge clk);
      chk("rst_stall", {31'd0, ex_if.stallreq_o}, 32'd0);
      chk("rst_whilo", {31'd0, ex_if.whilo_o}, 32'd0);
      chk("rst_hi", ex_if.hi_o, 32'd0);
      chk("rst_lo", ex_if.lo_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(8'h00, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);

      // Logic and shift operations
      @(posedge clk); #1;
      drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F0F0, 5'd5, 1'b1);
      @(negedge clk);
      chk("or_wdata", ex_if.wdata_o, 32'h00F0_FFF0);
      chk("or_wd", {27'd0, ex_if.wd_o}, 32'd5);
      chk("or_wreg", {31'd0, ex_if.wreg_o}, 32'd1);
      chk("or_stall", {31'd0, ex_if.stallreq_o}, 32'd0);
      alu_check("and", EXE_AND_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F0F0, 32'h0000_F000);
      alu_check("xor", EXE_XOR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F0F0, 32'h00F0_0FF0);
      alu_check("nor", EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F0F0, 32'hFF0F_000F);
      alu_check("sra", EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 32'hF800_0001);
      alu_check("sll", EXE_SLL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 32'h0000_0100);
      alu_check("srl", EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 32'h0800_0001);
      alu_check("sra_amt_low5", EXE_SRA_OP, EXE_RES_SHIFT, 32'h0000_0024, 32'h8000_0010, 32'hF800_0001);
      alu_check("sll_zero", EXE_SLL_OP, EXE_RES_SHIFT, 32'd0, 32'h1234_5678, 32'h1234_5678);
      alu_check("alusel_nop", EXE_OR_OP, EXE_RES_NOP, 32'h0000_FF00, 32'h00F0_F0F0, 32'd0);
      alu_check("alusel_unknown", EXE_OR_OP, 3'b111, 32'h0000_FF00, 32'h00F0_F0F0, 32'd0);

      // Divides
      run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 32);
      go_idle("divu_100_7");
      run_div("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32);
      go_idle("div_m7_2");
      run_div("div_7_m2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 32);
      go_idle("div_7_m2");
      run_div("divu_big_3", EXE_DIVU_OP, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA, 32);
      go_idle("divu_big_3");
      run_div("div_by_zero", EXE_DIV_OP, 32'd5, 32'd0, 32'd0, 32'd0, 1);
      // Back-to-back divide straight after DIV_END
      run_div("div_min_m1", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32);
      go_idle("div_min_m1");

      // Flush in the middle of a divide (cnt = 10)
      @(posedge clk); #1;
      drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd0, 1'b0);
      repeat (11) @(posedge clk);
      #1;
      chk("flush_pre_stall", {31'd0, ex_if.stallreq_o}, 32'd1);
      ex_if.flush_i = 1'b1;
      drive(8'h00, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      #1;
      chk("flush_stall", {31'd0, ex_if.stallreq_o}, 32'd0);
      @(posedge clk); #1;
      ex_if.flush_i = 1'b0;
      watch_no_whilo("flush", 40);
      run_div("after_flush", EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 32);
      go_idle("after_flush");

      // Asynchronous reset in the middle of a divide (cnt = 10)
      @(posedge clk); #1;
      drive(EXE_DIVU_OP, EXE_RES_LOGIC, 32'd100, 32'd7, 5'd5, 1'b1);
      repeat (11) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_stall", {31'd0, ex_if.stallreq_o}, 32'd0);
      chk("arst_whilo", {31'd0, ex_if.whilo_o}, 32'd0);
      chk("arst_wd", {27'd0, ex_if.wd_o}, 32'd0);
      chk("arst_wreg", {31'd0, ex_if.wreg_o}, 32'd0);
      chk("arst_wdata", ex_if.wdata_o, 32'd0);
      chk("arst_hi", ex_if.hi_o, 32'd0);
      chk("arst_lo", ex_if.lo_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(8'h00, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      chk("arst_idle_stall", {31'd0, ex_if.stallreq_o}, 32'd0);
      watch_no_whilo("arst", 40);
      run_div("after_rst", EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 32);
      go_idle("after_rst");

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
